// File: rtl/binary_to_ascii_pkg.sv
// binary_to_ascii_pkg
// Shared constants and helpers for the fixed-point to ASCII converter.
// Frame timing is expressed as frame-counter values: the converter loads
// at LOAD_C, publishes the fraction at DEC_DONE_C and the integer at
// INT_DONE_C, then wraps after FRAME_LEN cycles.
package binary_to_ascii_pkg;

    localparam logic [7:0]  ASCII_ZERO = 8'h30;

    localparam int unsigned FRAME_LEN  = 14;
    localparam int unsigned INT_BITS   = 12;
    localparam int unsigned INT_DIGITS = 4;
    localparam int unsigned DEC_BITS   = 8;
    localparam int unsigned DEC_DIGITS = 2;
    localparam int unsigned DEC_MAX    = 99;

    localparam int unsigned LOAD_C     = 0;
    localparam int unsigned DEC_DONE_C = 9;
    localparam int unsigned INT_DONE_C = 13;

    localparam int unsigned CNT_W      = $clog2(FRAME_LEN);

    // Map one BCD digit (0..9) to its ASCII character.
    function automatic logic [7:0] to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/binary_to_ascii_bcd_shift_add.sv
// bcd_shift_add
// Sequential double-dabble core: binary-to-BCD conversion one bit per step.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din and clear the BCD accumulator
//   step       : add 3 to every digit >= 5, then shift left one bit,
//                feeding the next MSB of the captured value
//   din        : binary value to convert (BITS wide)
//   bcd        : BCD accumulator, DIGITS nibbles, least significant digit
//                in bits [3:0]; valid after exactly BITS steps
// load takes priority over step.
module bcd_shift_add #(
    parameter int unsigned BITS   = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [BITS-1:0]       din,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [BITS-1:0]     bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;

    // Per-digit correction so that the following shift carries properly
    // into the next decimal digit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else if (load) begin
            bin_q <= din;
            bcd_q <= '0;
        end else if (step) begin
            bcd_q <= {bcd_adj[4*DIGITS-2:0], bin_q[BITS-1]};
            bin_q <= {bin_q[BITS-2:0], 1'b0};
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/binary_to_ascii.sv
// binary_to_ascii
// Free-running converter from a fixed-point value (12-bit integer part,
// 8-bit hundredths part) to ASCII decimal digits, one 14-cycle frame per
// conversion.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   int_part  : unsigned integer part, 0..4095
//   dec_part  : unsigned hundredths, 0..99 nominal (larger saturates to "99")
//   int_ascii : four ASCII digits, thousands in [31:24] .. units in [7:0]
//   dec_ascii : two ASCII digits, tenths in [15:8], hundredths in [7:0]
// Inputs are sampled only on the LOAD cycle; outputs are registered and
// held between their update edges.
module binary_to_ascii
    import binary_to_ascii_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] int_part,
    input  logic [7:0]  dec_part,
    output logic [31:0] int_ascii,
    output logic [15:0] dec_ascii
);

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    load;
    logic                    int_step;
    logic                    dec_step;
    logic                    dec_sat_q;
    logic [4*INT_DIGITS-1:0] int_bcd;
    logic [4*DEC_DIGITS-1:0] dec_bcd;
    logic [31:0]             int_ascii_d;
    logic [15:0]             dec_ascii_d;

    // Frame counter: 0..FRAME_LEN-1, wraps continuously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            cnt_d = '0;
        end
    end

    assign load     = (cnt_q == CNT_W'(LOAD_C));
    assign int_step = (cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_W'(INT_BITS));
    assign dec_step = (cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_W'(DEC_BITS));

    bcd_shift_add #(
        .BITS   (INT_BITS),
        .DIGITS (INT_DIGITS)
    ) u_int_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (int_step),
        .din   (int_part),
        .bcd   (int_bcd)
    );

    bcd_shift_add #(
        .BITS   (DEC_BITS),
        .DIGITS (DEC_DIGITS)
    ) u_dec_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (dec_step),
        .din   (dec_part),
        .bcd   (dec_bcd)
    );

    // Out-of-range fractions overflow the two-digit accumulator, so the
    // range decision is taken on the raw value at LOAD time instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_sat_q <= 1'b0;
        end else if (load) begin
            dec_sat_q <= (dec_part > 8'(DEC_MAX));
        end
    end

    always_comb begin
        int_ascii_d = '0;
        for (int unsigned i = 0; i < INT_DIGITS; i++) begin
            int_ascii_d[8*i +: 8] = to_ascii(int_bcd[4*i +: 4]);
        end
        dec_ascii_d = '0;
        for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
            dec_ascii_d[8*i +: 8] = to_ascii(dec_bcd[4*i +: 4]);
        end
        if (dec_sat_q) begin
            dec_ascii_d = {2{to_ascii(4'd9)}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ascii <= {INT_DIGITS{ASCII_ZERO}};
            dec_ascii <= {DEC_DIGITS{ASCII_ZERO}};
        end else begin
            if (cnt_q == CNT_W'(DEC_DONE_C)) begin
                dec_ascii <= dec_ascii_d;
            end
            if (cnt_q == CNT_W'(INT_DONE_C)) begin
                int_ascii <= int_ascii_d;
            end
        end
    end

endmodule

// File: tb/tb_binary_to_ascii.sv
// tb_binary_to_ascii
// Scoreboard bench: at every LOAD edge the expected ASCII strings for the
// sampled inputs are computed arithmetically and queued; a monitor pops them
// when the converter is due to publish and checks the outputs every cycle.
module tb_binary_to_ascii;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] int_part = '0;
    logic [7:0]  dec_part = '0;
    logic [31:0] int_ascii;
    logic [15:0] dec_ascii;

    int checks = 0;
    int failures = 0;

    logic [31:0] q_int[$];
    logic [15:0] q_dec[$];
    int unsigned edge_cnt = 0;
    logic [31:0] cur_int = 32'h30303030;
    logic [15:0] cur_dec = 16'h3030;

    binary_to_ascii dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_part  (int_part),
        .dec_part  (dec_part),
        .int_ascii (int_ascii),
        .dec_ascii (dec_ascii)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_int(input int v);
        return {8'(48 + v / 1000), 8'(48 + (v / 100) % 10),
                8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
    endfunction

    function automatic logic [15:0] model_dec(input int v);
        if (v > 99) return 16'h3939;
        return {8'(48 + v / 10), 8'(48 + v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame tracker: every 14th edge after reset release samples inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt = 0;
            q_int.delete();
            q_dec.delete();
        end else begin
            if (edge_cnt % 14 == 0) begin
                q_int.push_back(model_int(int'(int_part)));
                q_dec.push_back(model_dec(int'(dec_part)));
            end
            edge_cnt++;
        end
    end

    // Monitor: pops expectations on publish cycles, checks outputs every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_int = 32'h30303030;
            cur_dec = 16'h3030;
            check("reset_int", int_ascii, cur_int);
            check("reset_dec", {16'h0, dec_ascii}, {16'h0, cur_dec});
        end else if (edge_cnt > 0) begin
            if ((edge_cnt - 1) % 14 == 9) begin
                checks++;
                if (q_dec.size() == 0) begin
                    failures++;
                    $display("FAIL dec_queue: got empty expected entry at %0t", $time);
                end else begin
                    cur_dec = q_dec.pop_front();
                end
            end
            if ((edge_cnt - 1) % 14 == 13) begin
                checks++;
                if (q_int.size() == 0) begin
                    failures++;
                    $display("FAIL int_queue: got empty expected entry at %0t", $time);
                end else begin
                    cur_int = q_int.pop_front();
                end
            end
            check("mon_int", int_ascii, cur_int);
            check("mon_dec", {16'h0, dec_ascii}, {16'h0, cur_dec});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        #1;
        check("async_rst_int", int_ascii, 32'h30303030);
        check("async_rst_dec", {16'h0, dec_ascii}, 32'h3030);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for the negedge following the edge taken at counter value c.
    task automatic wait_phase(input int unsigned c, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(edge_cnt > 0 && (edge_cnt - 1) % 14 == c) && waited < 20);
        if (waited >= 20) begin
            checks++;
            failures++;
            $display("FAIL wait_phase: got timeout expected phase %0d", c);
        end
    endtask

    task automatic apply(input int i, input int d, input logic [31:0] ei, input logic [15:0] ed);
        @(negedge clk);
        int_part = 12'(i);
        dec_part = 8'(d);
        repeat (28) @(negedge clk);
        check("vec_int", int_ascii, ei);
        check("vec_dec", {16'h0, dec_ascii}, {16'h0, ed});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int since;

        // Latency from reset release with 1234.56 held.
        int_part = 12'd1234;
        dec_part = 8'd56;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        check("first_dec", {16'h0, dec_ascii}, 32'h3536);
        repeat (4) @(negedge clk);
        check("first_int", int_ascii, 32'h31323334);

        // Boundary vectors.
        apply(4095, 99,  32'h34303935, 16'h3939);
        apply(0,    5,   32'h30303030, 16'h3035);
        apply(7,    200, 32'h30303037, 16'h3939);
        apply(1000, 100, 32'h31303030, 16'h3939);

        // Inputs changed at c=3: current frame keeps captured values.
        apply(321, 12, 32'h30333231, 16'h3132);
        wait_phase(2, w);
        int_part = 12'd876;
        dec_part = 8'd43;
        since = 0;
        wait_phase(9, w);  since += w;
        check("midchg_old_dec", {16'h0, dec_ascii}, 32'h3132);
        wait_phase(13, w); since += w;
        check("midchg_old_int", int_ascii, 32'h30333231);
        wait_phase(9, w);  since += w;
        check("midchg_new_dec", {16'h0, dec_ascii}, 32'h3433);
        wait_phase(13, w); since += w;
        check("midchg_new_int", int_ascii, 32'h30383736);
        check("midchg_latency_ok", {31'h0, since <= 27}, 32'h1);

        // Reset mid-frame, frame restarts at c=0.
        repeat (5) @(negedge clk);
        int_part = 12'd2468;
        dec_part = 8'd80;
        do_reset();
        repeat (10) @(negedge clk);
        check("rst_restart_dec", {16'h0, dec_ascii}, 32'h3830);
        repeat (4) @(negedge clk);
        check("rst_restart_int", int_ascii, 32'h32343638);

        // Randomized traffic, checked by the monitor.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                int_part = 12'($urandom_range(0, 4095));
                if ($urandom_range(0, 3) == 0) dec_part = 8'($urandom_range(100, 255));
                else                           dec_part = 8'($urandom_range(0, 99));
            end
            if (n == 300) do_reset();
        end
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/binary_to_ascii.md
Name: binary_to_ascii

Overview:
- Converts a fixed-point value into ASCII decimal digits for character displays and serial logging.
- The value has a 12-bit unsigned integer part and an 8-bit hundredths part.
- Integer part becomes four ASCII digits; hundredths part becomes two.
- Sequential double-dabble converter that free-runs in repeating conversion frames; sits between sensor/arithmetic logic and a text output path.

Parameters:
- None. Widths are fixed: integer 12 bits / 4 digits, fraction 8 bits / 2 digits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- int_part  input  12  unsigned integer part, 0..4095
- dec_part  input  8  unsigned hundredths, 0..99 nominal
- int_ascii  output  32  ASCII digits; [31:24] thousands, [23:16] hundreds, [15:8] tens, [7:0] units
- dec_ascii  output  16  ASCII digits; [15:8] tenths, [7:0] hundredths

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, immediately, independent of clk):
  - int_ascii = 32'h30303030 ("0000"), dec_ascii = 16'h3030 ("00").
  - Frame counter = 0; BCD shift registers cleared.
- Frame: 14 cycles, counter c = 0..13, restarts at 0 after 13. Runs continuously after reset release.
- c=0 LOAD:
  - Capture int_part and dec_part into internal shift registers.
  - Clear the BCD accumulators.
  - Input changes at other times are ignored until the next LOAD.
- c=1..12 integer SHIFT, double-dabble:
  - Add 3 to each 4-bit BCD digit that is >=5.
  - Then shift the accumulator left by one, taking the next MSB of the captured int_part.
- c=1..8 fraction SHIFT: same algorithm on the 8-bit captured dec_part, 2-digit accumulator.
- c=9: register dec_ascii = {8'h30+tens, 8'h30+units}.
  - If the captured dec_part > 99, saturate dec_ascii to "99" (16'h3939).
- c=13: register int_ascii = {8'h30+d3, 8'h30+d2, 8'h30+d1, 8'h30+d0}.
- Leading zeros are emitted as '0' (0x30); no blanking, no sign.
- Latency, from the LOAD edge:
  - dec_ascii updates 9 clocks later.
  - int_ascii updates 13 clocks later.
  - Worst case from an input change to a reflecting output: 27 cycles.
- Outputs are held stable between their update edges; no combinational path from inputs to outputs.
- Reset mid-frame: outputs return to reset values at once; after release the frame restarts at c=0.
- Every output byte is always in 0x30..0x39.

Decomposition:
- Shared package binary_to_ascii_pkg:
  - ASCII_ZERO = 8'h30
  - FRAME_LEN = 14, INT_BITS = 12, INT_DIGITS = 4, DEC_BITS = 8, DEC_DIGITS = 2
  - DEC_MAX = 99
  - Cycle-index constants LOAD_C = 0, DEC_DONE_C = 9, INT_DONE_C = 13
- One natural sub-module: bcd_shift_add, parameterized by bit width and digit count.
  - Implements load/step of the add-3-then-shift iteration.
  - Instantiated twice, for the integer and fraction paths.
- Top level holds the frame counter, ASCII offsetting and the saturation rule.

Test Plan:
- Reset asserted asynchronously mid-frame -> int_ascii=32'h30303030 and dec_ascii=16'h3030 immediately; counter restarts at c=0 after release.
- int_part=12'd1234, dec_part=8'd56 held from reset release:
  - within 10 clocks, dec_ascii=16'h3536 ("56");
  - within 14 clocks, int_ascii=32'h31323334 ("1234").
- int_part=12'd4095, dec_part=8'd99 -> int_ascii=32'h34303935 ("4095"), dec_ascii=16'h3939 ("99").
- int_part=0, dec_part=5 -> int_ascii=32'h30303030 ("0000"), dec_ascii=16'h3035 ("05"), leading zeros kept.
- dec_part=8'd200 -> dec_ascii=16'h3939 (saturated); int_part=12'd7 -> int_ascii=32'h30303037.
- Inputs changed at c=3 within a frame -> outputs of that frame reflect the values captured at LOAD; new values appear in the following frame, at most 27 cycles after the change.
